sonar_scan_sched: RTL

Time-multiplexed scheduler for the five front/side ultrasonic rangers. Fires one sensor per fixed-length slot (round-robin, sensor 1 to 5) so that echoes cannot cross-talk. Measures each echo pulse width and converts it to centimetres without a divider. After each full scan it publishes all five distances plus the nearest-obstacle index and distance to the steering/motor logic.

---
 rtl/sonar_scan_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sonar_scan_sched.sv
// rtl/sonar_scan_sched.sv - round-robin ultrasonic ranger scheduler with divider-free cm conversion
// One sensor fires per fixed slot; a full scan publishes all distances plus the nearest obstacle.
module sonar_scan_sched #(
  parameter int         N_SENS     = 5,
  parameter int         TRIG_TICKS = 2,
  parameter int         SLOT_TICKS = 3000,
  parameter int         MAX_CM     = 400,
  parameter logic [8:0] NO_ECHO    = 9'h1FF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [N_SENS-1:0]   ECHO,
  output logic [N_SENS-1:0]   TRIG,
  output logic [9*N_SENS-1:0] DIST_ALL,
  output logic [2:0]          MIN_ID,
  output logic [8:0]          DISTANCE,
  output logic                FRAME_VALID,
  output logic                BUSY
);
  localparam int CW = $clog2(SLOT_TICKS);
  localparam int SW = (N_SENS > 1) ? $clog2(N_SENS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_LISTEN, S_MEASURE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       slot_q, slot_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [5:0]          acc_q, acc_d;
  logic [8:0]          cm_q, cm_d;
  logic [N_SENS-1:0]   sync1_q, sync2_q, prev_q;
  logic [8:0]          shadow_q [N_SENS];
  logic [8:0]          shadow_d [N_SENS];
  logic [9*N_SENS-1:0] dist_q, dist_d;
  logic [2:0]          min_id_q, min_id_d;
  logic [8:0]          distance_q, distance_d;
  logic                fv_q, fv_d;

  logic       echo_now, echo_prev, slot_end, last_slot, commit;
  logic [6:0] acc_sum;
  logic [8:0] cm_inc;
  logic [8:0] best_val;
  logic [2:0] best_id;

  assign echo_now  = sync2_q[sel_q];
  assign echo_prev = prev_q[sel_q];
  assign slot_end  = (slot_q == CW'(SLOT_TICKS - 1));
  assign last_slot = (sel_q == SW'(N_SENS - 1));
  assign acc_sum   = {1'b0, acc_q} + 7'd10;
  assign cm_inc    = (cm_q == 9'h1FF) ? cm_q : cm_q + 9'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      sel_q      <= '0;
      acc_q      <= '0;
      cm_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      for (int i = 0; i < N_SENS; i++) shadow_q[i] <= NO_ECHO;
      dist_q     <= {N_SENS{NO_ECHO}};
      min_id_q   <= '0;
      distance_q <= NO_ECHO;
      fv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sel_q      <= sel_d;
      acc_q      <= acc_d;
      cm_q       <= cm_d;
      sync1_q    <= ECHO;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      for (int i = 0; i < N_SENS; i++) shadow_q[i] <= shadow_d[i];
      dist_q     <= dist_d;
      min_id_q   <= min_id_d;
      distance_q <= distance_d;
      fv_q       <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    cm_d    = cm_q;
    commit  = 1'b0;
    for (int i = 0; i < N_SENS; i++) shadow_d[i] = shadow_q[i];
    if (!EN) begin
      state_d = S_IDLE;
      slot_d  = '0;
      sel_d   = '0;
      for (int i = 0; i < N_SENS; i++) shadow_d[i] = NO_ECHO;
    end else if (state_q == S_IDLE) begin
      state_d = S_TRIG;
      slot_d  = '0;
      sel_d   = '0;
    end else begin
      slot_d = slot_q + CW'(1);
      case (state_q)
        S_TRIG: if (slot_q == CW'(TRIG_TICKS - 1)) state_d = S_LISTEN;
        // The edge cycle is already the first high tick, so it is accumulated on entry.
        S_LISTEN: if (echo_now && !echo_prev) begin
          state_d = S_MEASURE;
          acc_d   = 6'd10;
          cm_d    = '0;
        end
        S_MEASURE: begin
          if (echo_now) begin
            if (acc_sum >= 7'd58) begin
              acc_d = 6'(acc_sum - 7'd58);
              cm_d  = cm_inc;
            end else begin
              acc_d = acc_sum[5:0];
            end
          end else begin
            shadow_d[sel_q] = (cm_q > 9'(MAX_CM)) ? NO_ECHO : cm_q;
            state_d         = S_HOLD;
          end
        end
        default: ;
      endcase
      if (slot_end) begin
        if (state_q == S_LISTEN || state_q == S_MEASURE) shadow_d[sel_q] = NO_ECHO;
        state_d = S_TRIG;
        slot_d  = '0;
        if (last_slot) begin
          sel_d  = '0;
          commit = 1'b1;
        end else begin
          sel_d = sel_q + SW'(1);
        end
      end
    end
  end

  // Nearest search runs on the next-shadow view so the last slot's result joins the frame.
  always_comb begin
    dist_d     = dist_q;
    min_id_d   = min_id_q;
    distance_d = distance_q;
    fv_d       = commit;
    best_val   = NO_ECHO;
    best_id    = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (shadow_d[i] != NO_ECHO && shadow_d[i] < best_val) begin
        best_val = shadow_d[i];
        best_id  = 3'(i + 1);
      end
    end
    if (commit) begin
      for (int i = 0; i < N_SENS; i++) dist_d[9*i +: 9] = shadow_d[i];
      min_id_d   = best_id;
      distance_d = best_val;
    end
  end

  always_comb begin
    TRIG = '0;
    if (state_q == S_TRIG) TRIG[sel_q] = 1'b1;
    BUSY = (state_q != S_IDLE);
  end

  assign DIST_ALL    = dist_q;
  assign MIN_ID      = min_id_q;
  assign DISTANCE    = distance_q;
  assign FRAME_VALID = fv_q;
endmodule
